// File: rtl/matrix_mult_t10x32_seq_pkg.sv
// Shared definitions for the transposed 32x10 Q8.24 matrix-vector multiplier:
// dimensions, fixed-point constants, FSM state encoding and the product
// rescale helper used by every MAC lane.
package matrix_mult_t10x32_seq_pkg;

  localparam int ROWS      = 32;
  localparam int COLS      = 10;
  localparam int W         = 32;
  localparam int FRAC_BITS = 24;
  localparam int ROW_BITS  = 5;

  localparam logic [W-1:0] ONE     = 32'h0100_0000;
  localparam logic [W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Rescale a Q16.48 product back to Q8.24: keep the sign bit and the 31 bits
  // just above the fractional cut, silently dropping the upper integer bits.
  function automatic logic [W-1:0] qTrunc(input logic [2*W-1:0] prod);
    return {prod[2*W-1], prod[W+FRAC_BITS-2:FRAC_BITS]};
  endfunction

endpackage

// File: rtl/matrix_mult_t10x32_seq_mac.sv
// One multiply-accumulate lane (mac_q8_24): signed 32x32 product, Q8.24
// rescale, then a 32-bit add onto the running accumulator. The add wraps by
// default; building with SATURATE_EN clamps it to SAT_MAX/SAT_MIN instead.
module mac_q8_24
  import matrix_mult_t10x32_seq_pkg::*;
(
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] acc_i,
  output logic [W-1:0] sum_o
);

  logic signed [2*W-1:0] prodFull;
  logic [W-1:0]          prodTrunc;
  logic [W-1:0]          rawSum;

  // Single-cycle multiply, rescale and add; the lane has no internal pipeline.
  always_comb begin
    prodFull  = $signed(a_i) * $signed(b_i);
    prodTrunc = qTrunc(prodFull);
    rawSum    = acc_i + prodTrunc;
  end

`ifdef SATURATE_EN
  logic overflow;

  // Signed overflow happens only when both addends share a sign and the sum flips it.
  always_comb begin
    overflow = (acc_i[W-1] == prodTrunc[W-1]) && (rawSum[W-1] != acc_i[W-1]);
    sum_o    = rawSum;
    if (overflow) begin
      sum_o = acc_i[W-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  // Plain two's complement wrap, matching the forward-layer arithmetic bit for bit.
  always_comb begin
    sum_o = rawSum;
  end
`endif

endmodule

// File: rtl/matrix_mult_t10x32_seq.sv
// Sequential transposed matrix-vector multiplier y = A^T * d for the backward
// pass. One row of A is consumed per cycle by COLS parallel MAC lanes, so a
// transaction takes 33 cycles from the accepted start to the done pulse.
// Optional build macro: SATURATE_EN (saturating accumulation in each lane).
module matrix_mult_t10x32_seq
  import matrix_mult_t10x32_seq_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [ROWS*COLS*W-1:0] A,
  input  logic [ROWS*W-1:0]      d,
  output logic [COLS*W-1:0]      y,
  output logic                   busy,
  output logic                   done
);

  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);

  state_t              state_q, state_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [W-1:0]        acc_q [COLS];
  logic [W-1:0]        acc_d [COLS];
  logic [W-1:0]        y_q   [COLS];
  logic [W-1:0]        y_d   [COLS];

  logic [W-1:0]        aRow   [COLS];
  logic [W-1:0]        dElem;
  logic [W-1:0]        macSum [COLS];

  // Pick out the current row of A and the matching error element; A is row-major with A[0][0] at the MSBs.
  always_comb begin
    for (int j = 0; j < COLS; j++) begin
      aRow[j] = A[ROWS*COLS*W-1 - W*(COLS*int'(row_q) + j) -: W];
    end
    dElem = d[ROWS*W-1 - W*int'(row_q) -: W];
  end

  genvar gj;
  generate
    for (gj = 0; gj < COLS; gj++) begin : g_lane
      mac_q8_24 u_mac (
        .a_i   (aRow[gj]),
        .b_i   (dElem),
        .acc_i (acc_q[gj]),
        .sum_o (macSum[gj])
      );
    end
  endgenerate

  // Next-state logic: IDLE waits for start, RUN walks the 32 rows, DONE publishes for one cycle.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    acc_d   = acc_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          row_d   = '0;
          for (int j = 0; j < COLS; j++) begin
            acc_d[j] = '0;
          end
        end
      end
      RUN: begin
        acc_d = macSum;
        row_d = row_q + ROW_BITS'(1);
        if (row_q == LAST_ROW) begin
          state_d = DONE;
          y_d     = macSum;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, row counter, accumulators and result register; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      for (int j = 0; j < COLS; j++) begin
        acc_q[j] <= '0;
        y_q[j]   <= '0;
      end
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

  // Flatten the result lanes with y[0] at the MSBs and derive the status flags from the state.
  always_comb begin
    for (int j = 0; j < COLS; j++) begin
      y[W*(COLS-j)-1 -: W] = y_q[j];
    end
    busy = (state_q != IDLE);
    done = (state_q == DONE);
  end

endmodule
